// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity modes.
// Used by both the TX and RX halves of the UART pair.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Controller-to-transmitter word handshake plus serial line status.
// The master drives words in; the slave serialises them.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic                 i_TX_DV;
  logic [DATA_BITS-1:0] i_TX_DATA;
  logic                 o_TX_SERIAL;
  logic                 o_TX_ACTIVE;
  logic                 o_TX_READY;
  logic                 o_TX_DONE;

  modport master (
    output i_TX_DV,
    output i_TX_DATA,
    input  o_TX_SERIAL,
    input  o_TX_ACTIVE,
    input  o_TX_READY,
    input  o_TX_DONE
  );

  modport slave (
    input  i_TX_DV,
    input  i_TX_DATA,
    output o_TX_SERIAL,
    output o_TX_ACTIVE,
    output o_TX_READY,
    output o_TX_DONE
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: ticks on the last clock of each serial bit.
// A restart pulls the count back to zero so every state starts aligned.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_RESTART,
  output logic o_TICK
);

  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $fatal(1, "uart_baud_cnt: CLKS_PER_BIT must be >= 2");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_TICK = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_RESTART || o_TICK) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-word holding buffer so
// consecutive frames leave the pin with no idle gap between them.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  uart_tx_cfg_if.slave  bus
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $fatal(1, "uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $fatal(1, "uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $fatal(1, "uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $fatal(1, "uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam tx_state_t  ST_PAR    = uart_pkg::PARITY;
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY != PAR_NONE);
  localparam logic       PAR_INV   = (PARITY == PAR_ODD);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic                 full_q, full_d;
  logic                 par_q, par_d;
  logic                 done_q, done_d;
  logic [3:0]           bit_q, bit_d;
  logic                 tick;
  logic                 accept;
  logic                 stop_end;
  logic                 ser;

  assign accept   = bus.i_TX_DV && !full_q;
  assign stop_end = (state_q == STOP) && tick && (bit_q == LAST_STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_CLK     (i_CLK),
    .i_RST_N   (i_RST_N),
    .i_RESTART (state_d != state_q),
    .o_TICK    (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    full_d  = full_q;
    par_d   = par_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = bus.i_TX_DATA;
          par_d   = (^bus.i_TX_DATA) ^ PAR_INV;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = PAR_EN ? ST_PAR : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PAR: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (stop_end) begin
          bit_d  = '0;
          done_d = 1'b1;
          // A buffered word wins; READY=0 guarantees no accept then.
          if (full_q) begin
            state_d = START;
            shift_d = buf_q;
            par_d   = (^buf_q) ^ PAR_INV;
            full_d  = 1'b0;
          end else if (accept) begin
            state_d = START;
            shift_d = bus.i_TX_DATA;
            par_d   = (^bus.i_TX_DATA) ^ PAR_INV;
          end else begin
            state_d = IDLE;
          end
        end else if (tick) begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept && state_q != IDLE && !stop_end) begin
      buf_d  = bus.i_TX_DATA;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q <= IDLE;
      shift_q <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      par_q   <= par_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    ser = 1'b1;
    unique case (state_q)
      START:   ser = 1'b0;
      DATA:    ser = shift_q[0];
      ST_PAR:  ser = par_q;
      default: ser = 1'b1;
    endcase
  end

  assign bus.o_TX_SERIAL = ser;
  assign bus.o_TX_ACTIVE = (state_q != IDLE);
  assign bus.o_TX_READY  = !full_q;
  assign bus.o_TX_DONE   = done_q;

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter, the successor of the fixed 8N1 transmitter. Serialises a DATA_BITS-wide word LSB-first with configurable parity and stop-bit count, and buffers one word so back-to-back frames go out with no idle gap. Sits between a byte-producing controller and the board TX pin, and is the TX half of the UART pair.

## Interface

- CLKS_PER_BIT, default 868, clock cycles per serial bit; legal range ≥ 2.
- DATA_BITS, default 8, data bits per frame; legal range 5..9.
- PARITY, default 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1; legal range 1..2.
- i_CLK  in  1  system clock; everything is on the rising edge.
- i_RST_N  in  1  synchronous, active-low reset.
- i_TX_DV  in  1  data valid; accepted only while o_TX_READY = 1.
- i_TX_DATA  in  DATA_BITS  word to send, bit 0 transmitted first.
- o_TX_SERIAL  out  1  serial line, idle high.
- o_TX_ACTIVE  out  1  high while a frame is on the line.
- o_TX_READY  out  1  holding buffer empty; a word can be accepted.
- o_TX_DONE  out  1  one-cycle pulse at the end of each frame.

## Operation

- Reset values while i_RST_N = 0 at an edge:
  - o_TX_SERIAL = 1, o_TX_ACTIVE = 0, o_TX_READY = 1, o_TX_DONE = 0.
  - FSM goes to IDLE.
  - Holding buffer is emptied.
- Reset mid-frame aborts the frame: the line returns high and no DONE pulse is produced.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- Transitions:
  - IDLE→START: on accept.
  - START→DATA: after 1 bit.
  - DATA→PARITY, or DATA→STOP when PARITY = 0: after DATA_BITS bits.
  - PARITY→STOP: after 1 bit.
  - STOP→START when the buffer is full or a word is accepted that same cycle; otherwise STOP→IDLE. This happens after STOP_BITS bits.
- Line level per state:
  - START = 0.
  - DATA = shift register bit 0; the register shifts right once per bit.
  - PARITY = XOR of the data bits for even parity, its inverse for odd.
  - STOP = 1.
- Accept is defined as i_TX_DV = 1 while o_TX_READY = 1 at an edge.
  - In IDLE, or in the final cycle of STOP, the word loads straight into the shift register and the buffer stays empty.
  - Otherwise the word goes into the holding buffer, and o_TX_READY = 0 from the next cycle.
- i_TX_DV while o_TX_READY = 0 is ignored. The word is dropped and there is no error flag.
- Parity is computed once at load time from the loaded word. A later i_TX_DATA change has no effect.
- Baud counter runs 0..CLKS_PER_BIT−1. It is reset on every state change. The bit index runs 0..DATA_BITS−1, then 0..STOP_BITS−1.
- Widths: the counter is $clog2(CLKS_PER_BIT) bits and the bit index is 4 bits. There is no arithmetic overflow anywhere.

## Timing

- Latency: accept at edge k drives o_TX_SERIAL = 0 and o_TX_ACTIVE = 1 from edge k (visible in cycle k+1).
- Each bit holds for exactly CLKS_PER_BIT cycles.
- Frame length is F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- o_TX_DONE = 1 for the single cycle after the last stop-bit cycle, i.e. from edge k+F.
  - In that same cycle o_TX_ACTIVE = 0 if the FSM returned to IDLE.
  - o_TX_ACTIVE stays 1 if the next frame's start bit has begun.
- Back-to-back frames: the next start bit begins at edge k+F with zero idle cycles, and o_TX_DONE still pulses.
- Buffer handover at edge k+F: o_TX_READY returns to 1 from edge k+F.
- Simultaneous events:
  - Accept in the last STOP cycle with the buffer empty: treated as an immediate load.
  - Accept in the last STOP cycle with the buffer full: impossible, because READY = 0.

## Structure

- Shared package uart_pkg holds:
  - the state encoding (tx_state_t: IDLE, START, DATA, PARITY, STOP);
  - the parity constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
- The RX block reuses uart_pkg.
- Sub-module uart_baud_cnt: counter with parameter CLKS_PER_BIT, inputs i_CLK, i_RST_N and a restart input, output a bit-end tick. It is shared with RX.
- Parameter legality is checked at elaboration; an illegal value is a fatal error.

## Test plan

- CLKS_PER_BIT = 4, 8N1, send 0x05: the line reads 0 then 1,0,1,0,0,0,0,0 then 1, each bit 4 cycles. o_TX_DONE pulses once, 40 cycles after accept.
- PARITY = 2, send 0x07: parity bit = 1. With PARITY = 1 the parity bit = 0. DATA_BITS = 7, STOP_BITS = 2 gives an 11-bit frame of 44 cycles.
- Back-to-back: send 0xA5, then 0x3C on the next cycle. READY goes 0 and then returns to 1 at the handover. The start bit of 0x3C follows the last stop bit with zero gap, and DONE pulses twice.
- i_TX_DV held while READY = 0 with a third word: that word is never transmitted and the next frames are unaffected.
- Assert reset mid-DATA of 0xFF: the line is high in the cycle after the reset edge, READY = 1, ACTIVE = 0, and there is no DONE. A new 0x00 after reset transmits correctly.
- Accept in the exact last STOP cycle: the next start bit begins at the boundary with no idle cycle.
